// File: rtl/dcp_dispatch.sv
// dcp_dispatch: console command dispatcher.
// Prints a '>' prompt on the shared transmitter, reads one command character
// from the shared receiver, and decodes it. A matching command selects one of
// four handlers and hands it the shared rx/tx channels until that handler
// raises its finish flag. Blank characters (space, CR, LF) are skipped
// silently. Any other character prints "?\r\n" and then a fresh prompt.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   sel_mode                   selected command code (IDLE_CODE when idle)
//   finish_h                   per-handler done flags
//   req/type_rx_h, req/type_tx_h, dout_h   per-handler channel requests
//   ack_rx_h, ack_tx_h         per-handler acks (routed only while running)
//   req_rx, type_rx, ack_rx, din_rx        shared receiver handshake
//   req_tx, type_tx, dout_tx, ack_tx       shared transmitter handshake
module dcp_dispatch #(
   parameter logic [7:0] CMD0      = 8'h49,
   parameter logic [7:0] CMD1      = 8'h44,
   parameter logic [7:0] CMD2      = 8'h52,
   parameter logic [7:0] CMD3      = 8'h54,
   parameter logic [7:0] IDLE_CODE = 8'h00
) (
   input  logic         clk,
   input  logic         rstn,
   output logic [7:0]   sel_mode,
   input  logic [3:0]   finish_h,
   input  logic [3:0]   req_rx_h,
   input  logic [3:0]   type_rx_h,
   input  logic [3:0]   req_tx_h,
   input  logic [3:0]   type_tx_h,
   input  logic [127:0] dout_h,
   output logic [3:0]   ack_rx_h,
   output logic [3:0]   ack_tx_h,
   output logic         req_rx,
   output logic         type_rx,
   input  logic         ack_rx,
   input  logic [31:0]  din_rx,
   output logic         req_tx,
   output logic         type_tx,
   output logic [31:0]  dout_tx,
   input  logic         ack_tx
);

   localparam int unsigned CMD_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 2;

   localparam logic [2:0] S_PROMPT = 3'd0;
   localparam logic [2:0] S_GETCMD = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_ERR_Q  = 3'd4;
   localparam logic [2:0] S_ERR_CR = 3'd5;
   localparam logic [2:0] S_ERR_LF = 3'd6;

   localparam logic [DATA_W-1:0] CH_PROMPT = 32'h0000_003E;
   localparam logic [DATA_W-1:0] CH_QUEST  = 32'h0000_003F;
   localparam logic [DATA_W-1:0] CH_CR     = 32'h0000_000D;
   localparam logic [DATA_W-1:0] CH_LF     = 32'h0000_000A;
   localparam logic [DATA_W-1:0] CH_SPACE  = 32'h0000_0020;

   localparam logic [CMD_W-1:0] C_SPACE = 8'h20;
   localparam logic [CMD_W-1:0] C_CR    = 8'h0D;
   localparam logic [CMD_W-1:0] C_LF    = 8'h0A;

   logic [2:0]        r_state,    w_state_nxt;
   logic [CMD_W-1:0]  r_sel_mode, w_sel_mode_nxt;
   logic              r_req_tx,   w_req_tx_nxt;
   logic              r_req_rx,   w_req_rx_nxt;
   logic [DATA_W-1:0] r_dout_tx,  w_dout_tx_nxt;
   logic [CMD_W-1:0]  r_cmd,      w_cmd_nxt;
   logic [IDX_W-1:0]  r_idx,      w_idx_nxt;

   logic              w_run;
   logic [DATA_W-1:0] w_char;
   logic [2:0]        w_char_next;
   logic [DATA_W-1:0] w_dout_sel;
   logic              w_unused;

   // Only the low byte of a received word carries the command.
   assign w_unused = ^din_rx[DATA_W-1:CMD_W];

   assign w_run = (r_state == S_RUN);

   // Character and successor for the four printing states.
   always_comb begin
      w_char      = CH_PROMPT;
      w_char_next = S_GETCMD;
      case (r_state)
         S_ERR_Q:  begin w_char = CH_QUEST;  w_char_next = S_ERR_CR; end
         S_ERR_CR: begin w_char = CH_CR;     w_char_next = S_ERR_LF; end
         S_ERR_LF: begin w_char = CH_LF;     w_char_next = S_PROMPT; end
         default:  begin w_char = CH_PROMPT; w_char_next = S_GETCMD; end
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_sel_mode_nxt = r_sel_mode;
      w_req_tx_nxt   = r_req_tx;
      w_req_rx_nxt   = r_req_rx;
      w_dout_tx_nxt  = r_dout_tx;
      w_cmd_nxt      = r_cmd;
      w_idx_nxt      = r_idx;
      case (r_state)
         S_PROMPT, S_ERR_Q, S_ERR_CR, S_ERR_LF: begin
            // Raise the request first; an ack only counts once it is up.
            if (!r_req_tx) begin
               w_req_tx_nxt  = 1'b1;
               w_dout_tx_nxt = w_char;
            end else if (ack_tx) begin
               w_req_tx_nxt  = 1'b0;
               w_dout_tx_nxt = CH_SPACE;
               w_state_nxt   = w_char_next;
            end
         end
         S_GETCMD: begin
            if (!r_req_rx) begin
               w_req_rx_nxt = 1'b1;
            end else if (ack_rx) begin
               w_cmd_nxt    = din_rx[CMD_W-1:0];
               w_req_rx_nxt = 1'b0;
               w_state_nxt  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Priority order so the lowest handler wins on duplicate codes.
            if (r_cmd == CMD0) begin
               w_sel_mode_nxt = CMD0;
               w_idx_nxt      = 2'd0;
               w_state_nxt    = S_RUN;
            end else if (r_cmd == CMD1) begin
               w_sel_mode_nxt = CMD1;
               w_idx_nxt      = 2'd1;
               w_state_nxt    = S_RUN;
            end else if (r_cmd == CMD2) begin
               w_sel_mode_nxt = CMD2;
               w_idx_nxt      = 2'd2;
               w_state_nxt    = S_RUN;
            end else if (r_cmd == CMD3) begin
               w_sel_mode_nxt = CMD3;
               w_idx_nxt      = 2'd3;
               w_state_nxt    = S_RUN;
            end else if (r_cmd == C_SPACE || r_cmd == C_CR || r_cmd == C_LF) begin
               w_state_nxt = S_GETCMD;
            end else begin
               w_state_nxt = S_ERR_Q;
            end
         end
         S_RUN: begin
            if (finish_h[r_idx]) begin
               w_sel_mode_nxt = IDLE_CODE;
               w_state_nxt    = S_PROMPT;
            end
         end
         default: begin
            w_state_nxt = S_PROMPT;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_PROMPT;
         r_sel_mode <= IDLE_CODE;
         r_req_tx   <= 1'b0;
         r_req_rx   <= 1'b0;
         r_dout_tx  <= CH_SPACE;
         r_cmd      <= '0;
         r_idx      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel_mode <= w_sel_mode_nxt;
         r_req_tx   <= w_req_tx_nxt;
         r_req_rx   <= w_req_rx_nxt;
         r_dout_tx  <= w_dout_tx_nxt;
         r_cmd      <= w_cmd_nxt;
         r_idx      <= w_idx_nxt;
      end
   end

   // While running, the selected handler drives the shared channels directly.
   assign w_dout_sel = dout_h[{r_idx, 5'd0} +: DATA_W];

   assign sel_mode = r_sel_mode;
   assign req_rx   = w_run ? req_rx_h[r_idx]  : r_req_rx;
   assign type_rx  = w_run ? type_rx_h[r_idx] : 1'b0;
   assign req_tx   = w_run ? req_tx_h[r_idx]  : r_req_tx;
   assign type_tx  = w_run ? type_tx_h[r_idx] : 1'b0;
   assign dout_tx  = w_run ? w_dout_sel       : r_dout_tx;

   // Acks reach only the selected handler, and only while it runs.
   always_comb begin
      ack_rx_h = '0;
      ack_tx_h = '0;
      if (w_run) begin
         ack_rx_h[r_idx] = ack_rx;
         ack_tx_h[r_idx] = ack_tx;
      end
   end

endmodule

// File: doc/dcp_dispatch.md
DCP_DISPATCH -- requirements
Module: dcp_dispatch

Interface
REQ-001 SHALL have parameter CMD0, default 8'h49 ('I'), command code of handler 0.
REQ-002 SHALL have parameter CMD1, default 8'h44 ('D'), command code of handler 1.
REQ-003 SHALL have parameter CMD2, default 8'h52 ('R'), command code of handler 2.
REQ-004 SHALL have parameter CMD3, default 8'h54 ('T'), command code of handler 3.
REQ-005 SHALL have parameter IDLE_CODE, default 8'h00, sel_mode value when no handler is selected; it differs from CMD0-CMD3.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rstn  in  1  asynchronous reset, active-low.
REQ-008 sel_mode  out  8  selected command code, broadcast to all handlers.
REQ-009 finish_h  in  4  per-handler done flag, bit k = handler k.
REQ-010 req_rx_h, type_rx_h, req_tx_h, type_tx_h  in  4 each  per-handler channel requests and types.
REQ-011 dout_h  in  128  per-handler tx data, handler k at bits [32k+31:32k].
REQ-012 ack_rx_h, ack_tx_h  out  4 each  per-handler acks.
REQ-013 req_rx, type_rx  out  1 each  request and type (0 = char) to the shared receiver.
REQ-014 ack_rx  in  1  one-cycle receiver ack pulse; din_rx  in  32  received data, valid with ack_rx.
REQ-015 req_tx, type_tx  out  1 each  request and type to the shared transmitter; dout_tx  out  32  tx data.
REQ-016 ack_tx  in  1  one-cycle transmitter ack pulse.

Function
REQ-017 SHALL implement states PROMPT, GETCMD, DECODE, RUN, ERR_Q, ERR_CR, ERR_LF.
REQ-018 PROMPT: req_tx registered high, type_tx=0, dout_tx=32'h3E; on ack_tx, req_tx<=0 and go to GETCMD.
REQ-019 GETCMD: req_rx registered high, type_rx=0; on ack_rx, capture din_rx[7:0] into cmd, req_rx<=0, go to DECODE.
REQ-020 DECODE lasts exactly one cycle: cmd==CMDk gives sel_mode<=CMDk, idx<=k, RUN; cmd in {8'h20, 8'h0D, 8'h0A} returns to GETCMD with nothing printed; any other value goes to ERR_Q.
REQ-021 If cmd matches several CMDk, the lowest k wins.
REQ-022 ERR_Q, ERR_CR, ERR_LF each send one char (8'h3F, 8'h0D, 8'h0A respectively) with the PROMPT handshake, then advance; ERR_LF goes to PROMPT.
REQ-023 In RUN: req_rx=req_rx_h[idx], type_rx=type_rx_h[idx], req_tx=req_tx_h[idx], type_tx=type_tx_h[idx], dout_tx=dout_h[idx] (combinational); ack_rx_h[idx]=ack_rx, ack_tx_h[idx]=ack_tx; all other ack bits 0.
REQ-024 Outside RUN, ack_rx_h and ack_tx_h SHALL be 4'b0 and handler requests are ignored.
REQ-025 In RUN, finish_h[idx]=1 SHALL set sel_mode<=IDLE_CODE and state<=PROMPT on that edge; finish_h of unselected handlers is ignored.
REQ-026 If finish_h[idx] and an ack pulse coincide, the ack is still routed that cycle and the RUN exit still occurs.
REQ-027 ack_tx/ack_rx pulses arriving while the dispatcher has no own request outstanding SHALL be ignored, outside RUN.
REQ-028 Outside RUN, dout_tx SHALL be 32'h20 whenever no char is being sent, and type_tx=0.
REQ-029 Latency from the ack_rx that delivers a valid command to sel_mode==CMDk SHALL be 2 cycles (capture, DECODE).

Reset
REQ-030 With rstn low, the block SHALL set: state=PROMPT, sel_mode=IDLE_CODE, req_tx=0, req_rx=0, cmd=0, idx=0, all acks 0.
REQ-031 Reset asserted mid-RUN or mid-handshake SHALL abort immediately with no pending request retained.
REQ-032 After rstn rises, the first action SHALL be the '>' prompt request on the next edge.

Verification
REQ-033 Reset release, ack_tx pulse -> exactly one tx of 32'h3E type 0, then req_rx=1.
REQ-034 din_rx=8'h44 with ack_rx -> sel_mode=8'h44 two cycles later; handler 1 req_tx_h/dout_h=32'h1234 appears on req_tx/dout_tx, and ack_tx is routed only to ack_tx_h[1].
REQ-035 din_rx=8'h5A -> tx sequence 3F, 0D, 0A, 3E with sel_mode held at 8'h00 throughout.
REQ-036 din_rx=8'h20 -> no tx, returns to GETCMD with req_rx=1.
REQ-037 In RUN idx=0: finish_h=4'b0010 -> no effect; then finish_h=4'b0001 -> sel_mode=8'h00 and a '>' prompt follows.
REQ-038 rstn pulsed low mid-RUN -> sel_mode=8'h00, req_tx=0, and the next action is the prompt.
